// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the serial adder-subtractor.
//   state_t  : FSM encoding (ST_IDLE, ST_RUN)
//   MODE_ADD : mode value selecting a+b
//   MODE_SUB : mode value selecting a-b (two's complement)
package serial_addsub_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle of serial_addsub.
//   start, mode, data_a, data_b : request side, driven by the master
//   busy, done, out, cout, ovf  : status/result side, driven by the slave
// Handshake: a request is taken on a rising edge where start=1 and busy=0;
// mode/data_a/data_b are sampled on that same edge only. busy stays high
// until the completing edge, after which done is high for exactly one cycle
// with out/cout/ovf already updated. out/cout/ovf hold until the next done.
// start is ignored while busy=1; start=1 during the done cycle is accepted.
interface serial_addsub_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;

  modport master (
    output start, mode, data_a, data_b,
    input  busy, done, out, cout, ovf
  );

  modport slave (
    input  start, mode, data_a, data_b,
    output busy, done, out, cout, ovf
  );

endinterface

// File: rtl/serial_addsub_digit_adder.sv
// Combinational DIGIT-bit ripple adder used once per clock by serial_addsub.
//   a, b  : digit operands
//   cin   : carry into bit 0
//   sum   : digit sum
//   cout  : carry out of the top bit
//   cmsb  : carry into the top bit (feeds signed overflow on the last digit)
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic cy;

  always_comb begin
    cy   = cin;
    sum  = '0;
    cmsb = cin;
    for (int i = 0; i < DIGIT; i++) begin
      // Capture the carry just before it enters the top bit.
      if (i == DIGIT - 1) cmsb = cy;
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    cout = cy;
  end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder-subtractor: operands captured on an accepted start,
// then DIGIT bits are added per clock, LSB first, over WIDTH/DIGIT cycles.
//   clk       : rising-edge clock
//   reset     : asynchronous, active-low reset
//   bus       : request/result bundle (slave side), see serial_addsub_if
//   dbg_state : current FSM state, for observation only
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic            clk,
  input  logic            reset,
  serial_addsub_if.slave  bus,
  output state_t          dbg_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;

  if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] out_q;
  logic             cout_q;
  logic             ovf_q;

  logic [DIGIT-1:0]       d_sum;
  logic                   d_cout;
  logic                   d_cmsb;
  logic [WIDTH+DIGIT-1:0] res_wide;
  logic [WIDTH-1:0]       res_next;
  logic                   last_digit;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .sum  (d_sum),
    .cout (d_cout),
    .cmsb (d_cmsb)
  );

  // New digit enters at the MSB end; after N digits the LSB digit has
  // reached bit 0. The wide form keeps DIGIT == WIDTH legal.
  assign res_wide   = {d_sum, res_q};
  assign res_next   = res_wide[WIDTH+DIGIT-1:DIGIT];
  assign last_digit = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.data_a;
            // Subtraction as a + ~b + 1: invert b, seed the carry with 1.
            b_q     <= (bus.mode == MODE_SUB) ? ~bus.data_b : bus.data_b;
            carry_q <= (bus.mode == MODE_SUB);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          res_q   <= res_next;
          carry_q <= d_cout;
          cnt_q   <= cnt_q + CW'(1);
          if (last_digit) begin
            out_q  <= res_next;
            cout_q <= d_cout;
            ovf_q  <= d_cmsb ^ d_cout;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.out   = out_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;
  assign dbg_state = state;

endmodule
